// File: rtl/rom_copy_pkg.sv
// Shared types and widths for the BASIC ROM-to-RAM copy sequencer.
package rom_copy_pkg;
    localparam int ROM_AW = 12;
    localparam int RAM_AW = 16;
    localparam int DW     = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE,
        DONE
    } state_t;
endpackage

// File: rtl/rom_copy_dma.sv
// Copies the synchronous BASIC ROM image into RAM while holding the 6502.
// Optional image checksum: define ROM_COPY_CHECKSUM_EN.
module rom_copy_dma
    import rom_copy_pkg::*;
#(
    parameter logic [RAM_AW-1:0] DEST_BASE    = 16'hE000,
    parameter int                LENGTH       = 4096,
    parameter bit                AUTO_START   = 1'b1,
    parameter logic [DW-1:0]     EXPECTED_SUM = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DW-1:0]     rom_dout,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_din,
    output logic              ram_we,
    input  logic              ram_ready,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done
`ifdef ROM_COPY_CHECKSUM_EN
    ,
    output logic              sum_ok
`endif
);

    localparam logic [ROM_AW-1:0] LAST = ROM_AW'(LENGTH - 1);

    state_t            state;
    logic [ROM_AW-1:0] idx;
    logic              auto_pend;
    logic              go;
    logic              accept;

    assign go       = start || auto_pend;
    assign accept   = (state == WRITE) && ram_ready;
    assign ram_din  = rom_dout;
    assign cpu_hold = busy;

    // auto_pend is a one-shot that fires on the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            rom_addr  <= '0;
            ram_addr  <= DEST_BASE;
            ram_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            auto_pend <= AUTO_START;
        end else begin
            auto_pend <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (go) begin
                        state    <= FETCH;
                        idx      <= '0;
                        rom_addr <= '0;
                        ram_addr <= DEST_BASE;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                FETCH: begin
                    state  <= WRITE;
                    ram_we <= 1'b1;
                end
                WRITE: begin
                    if (ram_ready) begin
                        ram_we <= 1'b0;
                        if (idx == LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            idx      <= idx + 1'b1;
                            rom_addr <= idx + 1'b1;
                            ram_addr <= DEST_BASE + RAM_AW'(idx) + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ROM_COPY_CHECKSUM_EN
    logic [DW-1:0] acc;
    logic [DW-1:0] acc_next;

    assign acc_next = acc + ram_din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            sum_ok <= 1'b0;
        end else if ((state == IDLE || state == DONE) && go) begin
            acc    <= '0;
            sum_ok <= 1'b0;
        end else if (accept) begin
            acc <= acc_next;
            if (idx == LAST)
                sum_ok <= (acc_next == EXPECTED_SUM);
        end
    end
`else
    localparam logic [DW-1:0] unused_sum = EXPECTED_SUM;
`endif

endmodule

// File: tb/tb_rom_copy_dma.sv
// Randomized bench for rom_copy_dma: ROM/RAM models plus image reference.
// Checksum checks active when ROM_COPY_CHECKSUM_EN is defined.
module tb_rom_copy_dma;

    localparam logic [7:0] IMG_SUM = 8'h5A;
    localparam logic [7:0] ROM0    = 8'hC3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        ram_ready = 1'b1;
    logic [11:0] rom_addr, rom_addr2;
    logic [7:0]  rom_dout, rom_dout2;
    logic [15:0] ram_addr, ram_addr2;
    logic [7:0]  ram_din, ram_din2;
    logic        ram_we, ram_we2;
    logic        cpu_hold, cpu_hold2;
    logic        busy, busy2;
    logic        done, done2;
`ifdef ROM_COPY_CHECKSUM_EN
    logic        sum_ok, sum_ok2;
`endif

    logic [7:0]  rom_mem [4096];
    logic [7:0]  ram_mem [65536];
    logic [15:0] log_a [$];
    logic [7:0]  log_d [$];
    logic [15:0] log2_a [$];
    logic [7:0]  log2_d [$];

    int n_cmp = 0;
    int n_err = 0;
    int stall_err = 0;
    bit stall_en = 1'b0;

    always #5 clk = ~clk;

    rom_copy_dma #(
        .DEST_BASE(16'hE000), .LENGTH(4096),
        .AUTO_START(1'b1), .EXPECTED_SUM(IMG_SUM)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_addr(rom_addr), .rom_dout(rom_dout),
        .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_we(ram_we), .ram_ready(ram_ready),
        .cpu_hold(cpu_hold), .busy(busy), .done(done)
`ifdef ROM_COPY_CHECKSUM_EN
        , .sum_ok(sum_ok)
`endif
    );

    rom_copy_dma #(
        .DEST_BASE(16'hFFFF), .LENGTH(1),
        .AUTO_START(1'b0), .EXPECTED_SUM(ROM0 ^ 8'h01)
    ) u_one (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .rom_addr(rom_addr2), .rom_dout(rom_dout2),
        .ram_addr(ram_addr2), .ram_din(ram_din2),
        .ram_we(ram_we2), .ram_ready(1'b1),
        .cpu_hold(cpu_hold2), .busy(busy2), .done(done2)
`ifdef ROM_COPY_CHECKSUM_EN
        , .sum_ok(sum_ok2)
`endif
    );

    // Registered ROM and accepting RAM
    always @(posedge clk) begin
        rom_dout  <= rom_mem[rom_addr];
        rom_dout2 <= rom_mem[rom_addr2];
        if (ram_we && ram_ready) begin
            ram_mem[ram_addr] = ram_din;
            log_a.push_back(ram_addr);
            log_d.push_back(ram_din);
        end
        if (ram_we2) begin
            log2_a.push_back(ram_addr2);
            log2_d.push_back(ram_din2);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            ram_ready = stall_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    // While a write is stalled, the request must not move
    logic [24:0] prev_req;
    bit          prev_stall = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && ({ram_we, ram_addr, ram_din} !== prev_req))
                stall_err++;
            prev_stall = ram_we && !ram_ready;
            prev_req   = {ram_we, ram_addr, ram_din};
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
            if (cyc > 20000) begin
                check({tag, " timeout"}, 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic check_image(input string tag);
        int bad = 0;
        check({tag, " count"}, log_a.size(), 4096);
        for (int i = 0; i < 4096; i++) begin
            if (ram_mem[16'hE000 + i] !== rom_mem[i]) bad++;
            if (i < log_a.size()) begin
                if (log_a[i] !== 16'(16'hE000 + i)) bad++;
                if (log_d[i] !== rom_mem[i]) bad++;
            end
        end
        check({tag, " image"}, bad, 0);
        check({tag, " last addr"},
              log_a.size() > 0 ? log_a[log_a.size() - 1] : 16'h0, 16'hEFFF);
    endtask

    task automatic clear_ram();
        log_a.delete();
        log_d.delete();
        for (int i = 0; i < 4096; i++) ram_mem[16'hE000 + i] = 8'h00;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " rom_addr"}, rom_addr, 0);
        check({tag, " ram_addr"}, ram_addr, 16'hE000);
        check({tag, " ram_we"}, ram_we, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " hold"}, cpu_hold, 0);
        check({tag, " done"}, done, 0);
`ifdef ROM_COPY_CHECKSUM_EN
        check({tag, " sum_ok"}, sum_ok, 0);
`endif
    endtask

    initial begin
        int cyc;
        int t;
        logic [7:0] part;
        logic [7:0] exp_sum;

        part = 8'h00;
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom);
        rom_mem[0] = ROM0;
        for (int i = 0; i < 4095; i++) part = part + rom_mem[i];
        rom_mem[4095] = IMG_SUM - part;
        exp_sum = 8'h00;
        for (int i = 0; i < 4096; i++) exp_sum = exp_sum + rom_mem[i];
        clear_ram();

        // Reset state and auto-start copy
        #17;
        check_reset("rst");
        check("rst one ram_addr", ram_addr2, 16'hFFFF);
        check("rst one done", done2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("auto hold", cpu_hold, 1);
        check("auto busy", busy, 1);
        check("auto rom_addr", rom_addr, 0);
        wait_done("auto", cyc);
        check("auto cycles", cyc, 8192);
        check("auto busy end", busy, 0);
        check_image("auto");
`ifdef ROM_COPY_CHECKSUM_EN
        check("auto sum_ok", sum_ok, exp_sum == IMG_SUM);
`endif

        // Stalled copy with an ignored mid-copy start
        clear_ram();
        stall_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart done clr", done, 0);
        check("restart busy", busy, 1);
`ifdef ROM_COPY_CHECKSUM_EN
        check("restart sum clr", sum_ok, 0);
`endif
        t = 0;
        while (log_a.size() < 100 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("byte100 reached", log_a.size() >= 100, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid start busy", busy, 1);
        wait_done("stall", cyc);
        check_image("stall");
        check("stall stable", stall_err, 0);
        stall_en = 1'b0;

        // Reset mid-copy at byte 0x7FF
        clear_ram();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (rom_addr != 12'h7FF && t < 10000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("byte7ff reached", rom_addr, 12'h7FF);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async");
        clear_ram();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rerun rom_addr", rom_addr, 0);
        check("rerun ram_addr", ram_addr, 16'hE000);
        check("rerun hold", cpu_hold, 1);
        wait_done("rerun", cyc);
        check("rerun cycles", cyc, 8192);
        check_image("rerun");

        // Single-byte copy to the top of memory
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        check("one busy", busy2, 1);
        cyc = 0;
        while (!done2 && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("one cycles", cyc, 2);
        check("one count", log2_a.size(), 1);
        check("one addr", log2_a.size() > 0 ? log2_a[0] : 16'h0, 16'hFFFF);
        check("one data", log2_d.size() > 0 ? log2_d[0] : 8'h0, rom_mem[0]);
`ifdef ROM_COPY_CHECKSUM_EN
        check("one sum_ok", sum_ok2, rom_mem[0] == (ROM0 ^ 8'h01));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
